arb_mux_param: RTL
==================

# arb_mux_param

Registered N:1 arbitrating multiplexer, generic in payload type and channel count. Each of 2**SEL input channels offers a payload of type T under a valid/ready handshake. One channel per cycle is granted, either round-robin or by an external selector, and its payload moves into a single output register. It sits between parallel producers of MuxParam_pkg types (op_codes_e_t, mem_ctl_st_t) and a single consumer, replacing the purely combinational selector where back-pressure and fairness are needed.

## Interface
Parameters:
- T, default logic [7:0]: payload type; any packed type, including MuxParam_pkg enums and structs.
- SEL, default 2: selector width; channel count N = 2**SEL; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Entry  in  T [N]  per-channel payload.
- EntryValid  in  N  per-channel payload valid.
- EntryReady  out  N  per-channel accept; at most one bit high.
- Mode  in  1  0 = fixed (Select chooses), 1 = round-robin.
- Select  in  SEL  channel index used in fixed mode.
- Sal  out  T  registered output payload.
- SalValid  out  1  output register holds data.
- SalReady  in  1  consumer accepts Sal this cycle.
- Grant  out  SEL  index of the channel that loaded the current Sal.

## Operation
- Output register states: EMPTY (SalValid=0) and FULL (SalValid=1).
- load_ok = !SalValid || SalReady.
- Candidate channel:
  - Fixed mode: candidate = Select. Only that channel is considered; all other EntryReady bits are 0.
  - Round-robin mode: scan from pointer ptr upward, modulo N. The first channel with EntryValid=1 is the candidate.
- EntryReady[c] = load_ok && EntryValid[c] for candidate c only. This is combinational from inputs and state. EntryReady never depends on Entry payload.
- Transfer on channel c when EntryValid[c] && EntryReady[c]. On that edge: Sal<=Entry[c], Grant<=c, SalValid<=1.
- If SalValid && SalReady and no input transfer occurs, SalValid<=0. Sal and Grant hold their values.
- Simultaneous output drain and input load: the new payload replaces the old one; SalValid stays 1. Full throughput is one transfer per cycle.
- ptr, round-robin only: after a transfer on c, ptr<=(c+1) mod N, wrapping from N-1 to 0. ptr is not updated in fixed mode or when no transfer occurs.
- Mode or Select changes take effect on the next combinational evaluation. The current Sal is unaffected.
- No valid inputs: EntryReady=0. Register drains normally.

## Timing
- Reset values, asynchronous: Sal=T'(0), SalValid=0, Grant=0, ptr=0, lock state cleared.
- Latency: one cycle from an input transfer edge to Sal/SalValid visible.
- Back-pressure: while SalValid=1 and SalReady=0, all EntryReady=0. Sal, Grant and SalValid are held stable.
- Reset asserted mid-transfer: in-flight Sal is discarded and no EntryReady is issued while rst_n=0. Operation resumes with ptr=0 on the first edge after deassertion.
- Producers must hold Entry/EntryValid stable until the transfer occurs. The block does not check this.

## Configuration
- ARB_MUX_LOCK_EN defined:
  - Adds input EntryLock [N].
  - In round-robin mode, a transfer on c with EntryLock[c]=1 sets locked=1 and lock_ch=c.
  - While locked, only lock_ch can be candidate, even if other channels are valid.
  - locked clears after the first transfer on lock_ch with EntryLock[lock_ch]=0; ptr then advances normally.
  - Fixed mode ignores EntryLock. Switching to fixed mode clears locked.
- ARB_MUX_LOCK_EN undefined:
  - Port EntryLock is absent, there is no lock state, and behaviour is as described above.

## Test plan
- Reset: drive rst_n=0 mid-stream with SalValid=1 -> Sal=0, SalValid=0, Grant=0, EntryReady=0 immediately. After release, round-robin starts at channel 0.
- Round-robin fairness: N=4, Mode=1, all EntryValid=1, SalReady=1, Entry[i]=i+8'h10 -> Grant sequence 0,1,2,3,0. Sal sequence 8'h10,11,12,13,10. One transfer per cycle.
- Skip and wrap: valid on channels 1 and 3 only, ptr=2 -> grant 3 then 1. ptr ends at 2.
- Back-pressure: SalValid=1, SalReady=0 for 3 cycles -> Sal and Grant unchanged and all EntryReady=0. When SalReady rises, the next channel loads on the same edge.
- Fixed mode with enum type T=op_codes_e_t: Select=2, channels 0..3 all valid -> only EntryReady[2]=1. Sal equals Entry[2], and Grant=2 on every transfer.
- Lock, with ARB_MUX_LOCK_EN: channel 1 sends 3 beats with EntryLock=1,1,0 while channel 2 is valid throughout -> Grant 1,1,1 then 2.

Source files
------------

// File: rtl/arb_mux_param.sv
// arb_mux_param: registered 2**SEL:1 arbitrating mux, round-robin or fixed select.
// Optional per-channel lock is enabled by defining ARB_MUX_LOCK_EN.
package MuxParam_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LD  = 4'h1,
    OP_ST  = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_JMP = 4'h8
  } op_codes_e_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [11:0] addr;
  } mem_ctl_st_t;
endpackage

module arb_mux_param #(
  parameter type T = logic [7:0],
  parameter int SEL = 2,
  localparam int N = 2**SEL
) (
  input  logic           clk,
  input  logic           rst_n,
  input  T               Entry [N],
  input  logic [N-1:0]   EntryValid,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]   EntryLock,
`endif
  output logic [N-1:0]   EntryReady,
  input  logic           Mode,
  input  logic [SEL-1:0] Select,
  output T               Sal,
  output logic           SalValid,
  input  logic           SalReady,
  output logic [SEL-1:0] Grant
);

  logic [SEL-1:0] ptr;
  logic [SEL-1:0] cand;
  logic           cand_ok;
  logic           load_ok;
  logic           xfer;

`ifdef ARB_MUX_LOCK_EN
  logic           locked;
  logic [SEL-1:0] lock_ch;
`endif

  assign load_ok = !SalValid || SalReady;

  // Descending scan so the nearest valid channel above ptr wins.
  always_comb begin
    cand    = Select;
    cand_ok = EntryValid[Select];
    if (Mode) begin
      cand    = ptr;
      cand_ok = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
        if (EntryValid[ptr + SEL'(i)]) begin
          cand    = ptr + SEL'(i);
          cand_ok = 1'b1;
        end
      end
`ifdef ARB_MUX_LOCK_EN
      if (locked) begin
        cand    = lock_ch;
        cand_ok = EntryValid[lock_ch];
      end
`endif
    end
  end

  always_comb begin
    EntryReady = '0;
    if (rst_n && load_ok && cand_ok)
      EntryReady[cand] = 1'b1;
  end

  assign xfer = |EntryReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sal      <= T'(0);
      SalValid <= 1'b0;
      Grant    <= '0;
      ptr      <= '0;
    end else begin
      if (xfer) begin
        Sal      <= Entry[cand];
        Grant    <= cand;
        SalValid <= 1'b1;
        if (Mode)
          ptr <= cand + SEL'(1);
      end else if (SalReady) begin
        SalValid <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (!Mode) begin
      locked <= 1'b0;
    end else if (xfer) begin
      if (EntryLock[cand]) begin
        locked  <= 1'b1;
        lock_ch <= cand;
      end else if (locked) begin
        locked <= 1'b0;
      end
    end
  end
`endif

endmodule
